param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 25 ++
 rtl/param_sync_fifo.sv | 111 +++++++++++
 tb/tb_param_sync_fifo.sv | 135 +++++++++++++
 4 files changed

// File: rtl/param_sync_fifo_pkg.sv
// rtl/param_sync_fifo_pkg.sv - shared defaults and read-mode enum for param_sync_fifo
package param_sync_fifo_pkg;

  localparam int FIFO_DW_DEF    = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - single-clock storage array, one write port, one asynchronous read port
module fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  // No reset on the array: contents survive rst by design.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - synchronous FIFO with arbitrary depth, status pulses and STD/FWFT read modes
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DW_DEF,
  parameter int DEPTH      = FIFO_DEPTH_DEF,
  parameter int AF_TH      = DEPTH - 1,
  parameter int AE_TH      = 1,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       rd_valid,
  output logic                       wr_ack,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       full,
  output logic                       empty,
  output logic                       almostfull,
  output logic                       almostempty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  mem_we;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almostfull  = (count >= CW'(AF_TH));
  assign almostempty = !empty && (count <= CW'(AE_TH));

  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);
  assign mem_we    = wr_accept && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= ptr_next(wr_ptr);
      if (rd_accept) rd_ptr <= ptr_next(rd_ptr);
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      wr_ack    <= wr_accept;
      overflow  <= wr_en && !wr_accept;
      underflow <= rd_en && !rd_accept;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      // Head word is visible as soon as it lands; masked to zero while empty.
      assign data_out = empty ? '0 : mem_rdata;
      assign rd_valid = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_accept;
          if (rd_accept) dout_q <= mem_rdata;
        end
      end

      assign data_out = dout_q;
      assign rd_valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - scoreboard bench for standard (depth 8) and FWFT (depth 5) FIFOs
module tb_param_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_wr, a_rd;
  logic [15:0] a_din, a_dout;
  logic        a_rd_valid, a_wr_ack, a_overflow, a_underflow;
  logic        a_full, a_empty, a_af, a_ae;
  logic [3:0]  a_count;

  logic        b_rst, b_wr, b_rd;
  logic [15:0] b_din, b_dout;
  logic        b_rd_valid, b_wr_ack, b_overflow, b_underflow;
  logic        b_full, b_empty, b_af, b_ae;
  logic [2:0]  b_count;

  param_sync_fifo #(.DATA_WIDTH(16), .DEPTH(8), .FWFT(0)) dut_a (
    .clk(clk), .rst(a_rst), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd),
    .data_out(a_dout), .rd_valid(a_rd_valid), .wr_ack(a_wr_ack),
    .overflow(a_overflow), .underflow(a_underflow), .full(a_full),
    .empty(a_empty), .almostfull(a_af), .almostempty(a_ae), .count(a_count)
  );

  param_sync_fifo #(.DATA_WIDTH(16), .DEPTH(5), .FWFT(1)) dut_b (
    .clk(clk), .rst(b_rst), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd),
    .data_out(b_dout), .rd_valid(b_rd_valid), .wr_ack(b_wr_ack),
    .overflow(b_overflow), .underflow(b_underflow), .full(b_full),
    .empty(b_empty), .almostfull(b_af), .almostempty(b_ae), .count(b_count)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int          ma_cnt = 0;
  int          mb_cnt = 0;
  logic [15:0] ma_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic r_st, input logic w, input logic r, input logic [15:0] d);
    logic racc, wacc;
    a_rst = r_st; a_wr = w; a_rd = r; a_din = d;
    racc = !r_st && r && (ma_cnt != 0);
    wacc = !r_st && w && ((ma_cnt != 8) || racc);
    if (r_st) begin
      ma_cnt = 0; qa.delete(); ma_dout = '0;
    end else begin
      if (racc) begin ma_dout = qa.pop_front(); ma_cnt--; end
      if (wacc) begin qa.push_back(d); ma_cnt++; end
    end
    @(posedge clk); #1;
    chk("a_count", a_count, ma_cnt);
    chk("a_wr_ack", a_wr_ack, wacc);
    chk("a_overflow", a_overflow, !r_st && w && !wacc);
    chk("a_underflow", a_underflow, !r_st && r && !racc);
    chk("a_rd_valid", a_rd_valid, racc);
    chk("a_data_out", a_dout, ma_dout);
    chk("a_full", a_full, ma_cnt == 8);
    chk("a_empty", a_empty, ma_cnt == 0);
    chk("a_almostfull", a_af, ma_cnt >= 7);
    chk("a_almostempty", a_ae, ma_cnt == 1);
    @(negedge clk);
  endtask

  task automatic step_b(input logic r_st, input logic w, input logic r, input logic [15:0] d);
    logic racc, wacc;
    logic [15:0] unused_word;
    b_rst = r_st; b_wr = w; b_rd = r; b_din = d;
    racc = !r_st && r && (mb_cnt != 0);
    wacc = !r_st && w && ((mb_cnt != 5) || racc);
    if (r_st) begin
      mb_cnt = 0; qb.delete();
    end else begin
      if (racc) begin unused_word = qb.pop_front(); mb_cnt--; end
      if (wacc) begin qb.push_back(d); mb_cnt++; end
    end
    @(posedge clk); #1;
    chk("b_count", b_count, mb_cnt);
    chk("b_wr_ack", b_wr_ack, wacc);
    chk("b_overflow", b_overflow, !r_st && w && !wacc);
    chk("b_underflow", b_underflow, !r_st && r && !racc);
    chk("b_empty", b_empty, mb_cnt == 0);
    chk("b_full", b_full, mb_cnt == 5);
    chk("b_almostfull", b_af, mb_cnt >= 4);
    chk("b_rd_valid", b_rd_valid, mb_cnt != 0);
    if (mb_cnt != 0) chk("b_head", b_dout, qb[0]);
    else chk("b_data_out_empty", b_dout, 0);
    @(negedge clk);
  endtask

  initial begin
    a_rst = 1'b1; a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
    b_rst = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
    @(negedge clk);

    // Standard-read FIFO, depth 8
    step_a(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 1; i <= 8; i++) step_a(1'b0, 1'b1, 1'b0, 16'(i));
    step_a(1'b0, 1'b1, 1'b0, 16'hBEEF);
    step_a(1'b0, 1'b1, 1'b1, 16'h00AA);
    for (int i = 0; i < 8; i++) step_a(1'b0, 1'b0, 1'b1, 16'h0000);
    step_a(1'b0, 1'b0, 1'b1, 16'h0000);
    step_a(1'b0, 1'b1, 1'b1, 16'h0055);
    step_a(1'b0, 1'b1, 1'b0, 16'h0066);
    step_a(1'b0, 1'b1, 1'b1, 16'h0077);
    step_a(1'b1, 1'b1, 1'b1, 16'h0088);
    step_a(1'b0, 1'b1, 1'b0, 16'h0099);
    step_a(1'b0, 1'b0, 1'b1, 16'h0000);
    step_a(1'b0, 1'b0, 1'b0, 16'h0000);
    a_rst = 1'b1;

    // FWFT FIFO, depth 5: 20 interleaved writes cross several wraps
    step_b(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 20; i++) step_b(1'b0, 1'b1, (i % 4) != 0, 16'(16'h0100 + i));
    for (int i = 0; i < 6; i++) step_b(1'b0, 1'b0, 1'b1, 16'h0000);
    step_b(1'b0, 1'b1, 1'b0, 16'h0CAF);
    step_b(1'b1, 1'b1, 1'b1, 16'h0DAD);
    step_b(1'b0, 1'b1, 1'b1, 16'h0123);
    step_b(1'b0, 1'b0, 1'b1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
